// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and constants for the SDRAM access arbiter.
// Optional build macro: JTFRAME_SDRAM_ARB_PRIO_EN (fixed slot priority).
package jtframe_sdram_arb_pkg;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned SLOT_IW = 2;

    localparam logic [1:0] DQM_LO   = 2'b10;
    localparam logic [1:0] DQM_HI   = 2'b01;
    localparam logic [1:0] DQM_WORD = 2'b00;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_SLOT, SRC_PROG, SRC_RFSH} src_t;

    // Byte lane enable for a download write: mask the half not being written
    function automatic logic [1:0] prog_dqm(input logic a0);
        return a0 ? DQM_HI : DQM_LO;
    endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// Combinational 4-way slot picker: rotating search from ptr+1, or fixed
// lowest-index priority when JTFRAME_SDRAM_ARB_PRIO_EN is defined.
module jtframe_arb_pick
    import jtframe_sdram_arb_pkg::*;
(
    input  logic [SLOTS-1:0]   req,
    input  logic [SLOT_IW-1:0] ptr,
    output logic [SLOTS-1:0]   gnt,
    output logic [SLOT_IW-1:0] idx
);

`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (req[SLOT_IW'(i)]) begin
                gnt                = '0;
                gnt[SLOT_IW'(i)]   = 1'b1;
                idx                = SLOT_IW'(i);
            end
        end
    end
`else
    always_comb begin
        logic [SLOT_IW-1:0] cand;
        logic               found;
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(SLOTS); k++) begin
            cand = ptr + SLOT_IW'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Shares one SDRAM controller port among four read slots, download writes
// and refresh; one transaction in flight. Macro: JTFRAME_SDRAM_ARB_PRIO_EN.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [AW:0]       prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              prog_we,
    output logic              prog_busy,
    output logic              prog_rdy,
    input  logic              rfsh_win,
    input  logic [4*AW-1:0]   slot_addr,
    input  logic [3:0]        slot_req,
    output logic [3:0]        slot_ok,
    output logic [DW-1:0]     slot_dout,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic              sdram_rfsh,
    output logic [AW-1:0]     sdram_addr,
    output logic [DW-1:0]     sdram_din,
    output logic [1:0]        sdram_dqm,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [DW-1:0]     sdram_dout
);

    state_t             state, state_nx;
    src_t               src, src_nx;
    logic [SLOT_IW-1:0] cur_slot, slot_nx, ptr, ptr_nx;
    logic               rfsh_win_q, rfsh_pend, rfsh_pend_nx, rfsh_req_c;
    logic               prog_pend, prog_pend_nx;
    logic [AW:0]        prog_addr_q, prog_addr_nx;
    logic [7:0]         prog_data_q, prog_data_nx;

    logic               req_nx, we_nx, rfsh_nx, prog_rdy_nx, prog_busy_nx;
    logic [AW-1:0]      addr_nx, sel_addr;
    logic [DW-1:0]      din_nx, dout_nx;
    logic [1:0]         dqm_nx;
    logic [3:0]         ok_nx, slot_elig, pick_gnt;
    logic [SLOT_IW-1:0] pick_idx;

    // Slots are held off during downloads and for one cycle after any read return
    assign slot_elig  = (downloading || slot_ok != 4'd0) ? 4'd0 : slot_req;
    assign rfsh_req_c = rfsh_pend | (rfsh_win & ~rfsh_win_q);

    jtframe_arb_pick u_pick (
        .req (slot_elig),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (pick_idx == SLOT_IW'(i)) sel_addr = slot_addr[i*AW +: AW];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        src_nx       = src;
        slot_nx      = cur_slot;
        ptr_nx       = ptr;
        rfsh_pend_nx = rfsh_req_c;
        prog_pend_nx = prog_pend;
        prog_addr_nx = prog_addr_q;
        prog_data_nx = prog_data_q;
        req_nx       = sdram_req;
        we_nx        = sdram_we;
        rfsh_nx      = sdram_rfsh;
        addr_nx      = sdram_addr;
        din_nx       = sdram_din;
        dqm_nx       = sdram_dqm;
        ok_nx        = '0;
        dout_nx      = slot_dout;
        prog_rdy_nx  = 1'b0;
        prog_busy_nx = prog_busy;

        if (prog_we && !prog_busy) begin
            prog_addr_nx = prog_addr;
            prog_data_nx = prog_data;
            prog_pend_nx = 1'b1;
            prog_busy_nx = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (prog_pend) begin
                    state_nx     = REQ;
                    src_nx       = SRC_PROG;
                    prog_pend_nx = 1'b0;
                    req_nx       = 1'b1;
                    we_nx        = 1'b1;
                    rfsh_nx      = 1'b0;
                    addr_nx      = prog_addr_q[AW:1];
                    din_nx       = DW'({prog_data_q, prog_data_q});
                    dqm_nx       = prog_dqm(prog_addr_q[0]);
                end else if (rfsh_req_c) begin
                    state_nx     = REQ;
                    src_nx       = SRC_RFSH;
                    rfsh_pend_nx = 1'b0;
                    req_nx       = 1'b1;
                    we_nx        = 1'b0;
                    rfsh_nx      = 1'b1;
                    addr_nx      = '0;
                    din_nx       = '0;
                    dqm_nx       = DQM_WORD;
                end else if (pick_gnt != 4'd0) begin
                    state_nx     = REQ;
                    src_nx       = SRC_SLOT;
                    slot_nx      = pick_idx;
                    ptr_nx       = pick_idx;
                    req_nx       = 1'b1;
                    we_nx        = 1'b0;
                    rfsh_nx      = 1'b0;
                    addr_nx      = sel_addr;
                    din_nx       = '0;
                    dqm_nx       = DQM_WORD;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_nx   = 1'b0;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (sdram_rdy) begin
                    state_nx = IDLE;
                    src_nx   = SRC_NONE;
                    if (src == SRC_SLOT) begin
                        ok_nx[cur_slot] = 1'b1;
                        dout_nx         = sdram_dout;
                    end else if (src == SRC_PROG) begin
                        prog_rdy_nx  = 1'b1;
                        prog_busy_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src         <= SRC_NONE;
            cur_slot    <= '0;
            ptr         <= SLOT_IW'(SLOTS - 1);
            rfsh_win_q  <= 1'b0;
            rfsh_pend   <= 1'b0;
            prog_pend   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            sdram_req   <= 1'b0;
            sdram_we    <= 1'b0;
            sdram_rfsh  <= 1'b0;
            sdram_addr  <= '0;
            sdram_din   <= '0;
            sdram_dqm   <= '0;
            slot_ok     <= '0;
            slot_dout   <= '0;
            prog_rdy    <= 1'b0;
            prog_busy   <= 1'b0;
        end else begin
            state       <= state_nx;
            src         <= src_nx;
            cur_slot    <= slot_nx;
            ptr         <= ptr_nx;
            rfsh_win_q  <= rfsh_win;
            rfsh_pend   <= rfsh_pend_nx;
            prog_pend   <= prog_pend_nx;
            prog_addr_q <= prog_addr_nx;
            prog_data_q <= prog_data_nx;
            sdram_req   <= req_nx;
            sdram_we    <= we_nx;
            sdram_rfsh  <= rfsh_nx;
            sdram_addr  <= addr_nx;
            sdram_din   <= din_nx;
            sdram_dqm   <= dqm_nx;
            slot_ok     <= ok_nx;
            slot_dout   <= dout_nx;
            prog_rdy    <= prog_rdy_nx;
            prog_busy   <= prog_busy_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Scoreboard bench for jtframe_sdram_arb: stimulus pushes expected SDRAM
// commands and returns, a negedge monitor pops and compares them.
module tb_jtframe_sdram_arb;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;

    localparam logic [1:0] EV_CMD  = 2'd1;
    localparam logic [1:0] EV_OK   = 2'd2;
    localparam logic [1:0] EV_PRDY = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        we;
        logic        rfsh;
        logic [21:0] addr;
        logic [15:0] din;
        logic [1:0]  dqm;
        logic [3:0]  ok;
        logic [15:0] dout;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            downloading;
    logic [AW:0]     prog_addr;
    logic [7:0]      prog_data;
    logic            prog_we;
    logic            prog_busy, prog_rdy;
    logic            rfsh_win;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_req, slot_ok;
    logic [DW-1:0]   slot_dout;
    logic            sdram_req, sdram_we, sdram_rfsh;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_din;
    logic [1:0]      sdram_dqm;
    logic            sdram_ack, sdram_rdy;
    logic [DW-1:0]   sdram_dout;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  ev_idx = 0;
    ev_t sb[$];

    int          ctl_lat = 4;
    int          ctl_cnt = 0;
    logic [21:0] ctl_addr;
    logic        req_q;

    always #5 clk = ~clk;

    jtframe_sdram_arb #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_we     (prog_we),
        .prog_busy   (prog_busy),
        .prog_rdy    (prog_rdy),
        .rfsh_win    (rfsh_win),
        .slot_addr   (slot_addr),
        .slot_req    (slot_req),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_we    (sdram_we),
        .sdram_rfsh  (sdram_rfsh),
        .sdram_addr  (sdram_addr),
        .sdram_din   (sdram_din),
        .sdram_dqm   (sdram_dqm),
        .sdram_ack   (sdram_ack),
        .sdram_rdy   (sdram_rdy),
        .sdram_dout  (sdram_dout)
    );

    function automatic logic [15:0] rd_data(input logic [21:0] a);
        if (a == 22'h01234) return 16'hBEEF;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Controller model: ack on the first cycle of a request, rdy ctl_lat cycles later
    initial begin
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b0;
        sdram_dout = '0;
        ctl_addr   = '0;
        forever begin
            @(posedge clk); #1;
            sdram_ack = 1'b0;
            sdram_rdy = 1'b0;
            if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    sdram_rdy  = 1'b1;
                    sdram_dout = rd_data(ctl_addr);
                end
            end else if (sdram_req && !rst) begin
                sdram_ack = 1'b1;
                ctl_addr  = sdram_addr;
                ctl_cnt   = ctl_lat;
            end
        end
    end

    task automatic push_cmd(input logic we, input logic rf, input logic [21:0] a,
                            input logic [15:0] d, input logic [1:0] m);
        ev_t e;
        e = '0; e.kind = EV_CMD; e.we = we; e.rfsh = rf; e.addr = a; e.din = d; e.dqm = m;
        sb.push_back(e);
    endtask

    task automatic push_ok(input logic [3:0] ok, input logic [15:0] d);
        ev_t e;
        e = '0; e.kind = EV_OK; e.ok = ok; e.dout = d;
        sb.push_back(e);
    endtask

    task automatic push_prdy();
        ev_t e;
        e = '0; e.kind = EV_PRDY;
        sb.push_back(e);
    endtask

    task automatic check_ev(input ev_t got);
        ev_t exp;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event%0d got=%h required=none", ev_idx, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL event%0d got=%h required=%h", ev_idx, got, exp);
            end
        end
        ev_idx++;
    endtask

    task automatic check(input string nm, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return 96'({sdram_req, sdram_we, sdram_rfsh, sdram_addr, sdram_din, sdram_dqm,
                    slot_ok, slot_dout, prog_busy, prog_rdy});
    endfunction

    // Monitor: every command issue, read return and write completion is an event
    always @(negedge clk) begin : mon
        ev_t e;
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            if (sdram_req && !req_q) begin
                e = '0; e.kind = EV_CMD; e.we = sdram_we; e.rfsh = sdram_rfsh;
                e.addr = sdram_addr; e.din = sdram_din; e.dqm = sdram_dqm;
                check_ev(e);
            end
            if (slot_ok != 4'd0) begin
                e = '0; e.kind = EV_OK; e.ok = slot_ok; e.dout = slot_dout;
                check_ev(e);
            end
            if (prog_rdy) begin
                e = '0; e.kind = EV_PRDY;
                check_ev(e);
            end
            req_q <= sdram_req;
        end
    end

    task automatic wait_ok(input int idx, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (slot_ok[idx]) got = 1'b1;
        end
        check(nm, 96'(got), 96'(1));
    endtask

    task automatic wait_prdy(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (prog_rdy) begin
                got = 1'b1;
                check({nm, "_busy_at_rdy"}, 96'(prog_busy), 96'(0));
            end
        end
        check(nm, 96'(got), 96'(1));
    endtask

    task automatic prog_pulse(input logic [AW:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_addr = a; prog_data = d; prog_we = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 96'(0));
        rst = 1'b0;
    endtask

    logic [21:0] rr_addr [4] = '{22'h00100, 22'h00211, 22'h00322, 22'h00433};

    initial begin
        rst = 1'b1; downloading = 1'b0; prog_addr = '0; prog_data = '0; prog_we = 1'b0;
        rfsh_win = 1'b0; slot_addr = '0; slot_req = '0;
        do_reset();

        // Single read from slot 2
        ctl_lat = 4;
        push_cmd(1'b0, 1'b0, 22'h01234, 16'h0000, 2'b00);
        push_ok(4'b0100, 16'hBEEF);
        @(negedge clk);
        slot_addr[2*AW +: AW] = 22'h01234;
        slot_req[2] = 1'b1;
        wait_ok(2, "single_read_ok");
        slot_req = '0;
        repeat (5) @(negedge clk);

        // All four slots held high from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) slot_addr[i*AW +: AW] = rr_addr[i];
`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b0, 1'b0, rr_addr[0], 16'h0000, 2'b00);
            push_ok(4'b0001, rd_data(rr_addr[0]));
        end
`else
        for (int i = 0; i < 5; i++) begin
            push_cmd(1'b0, 1'b0, rr_addr[i % 4], 16'h0000, 2'b00);
            push_ok(4'(1 << (i % 4)), rd_data(rr_addr[i % 4]));
        end
`endif
        @(negedge clk);
        slot_req = 4'b1111;
        begin
            int cnt = 0;
            for (int i = 0; i < 300 && cnt < 5; i++) begin
                @(negedge clk);
                if (slot_ok != 4'd0) cnt++;
            end
            slot_req = '0;
            check("rr_five_returns", 96'(cnt), 96'(5));
        end
        repeat (5) @(negedge clk);

        // Download write to an odd byte address; slot 3 must stay starved
        downloading = 1'b1;
        slot_addr[3*AW +: AW] = 22'h0ABCD;
        slot_req[3] = 1'b1;
        push_cmd(1'b1, 1'b0, 22'h000002, 16'h5A5A, 2'b01);
        push_prdy();
        prog_pulse(23'h000005, 8'h5A);
        check("prog_busy_after_we", 96'(prog_busy), 96'(1));
        wait_prdy("prog_odd_rdy");
        repeat (20) @(negedge clk);

        // Second prog_we two cycles after the first is dropped
        push_cmd(1'b1, 1'b0, 22'h000008, 16'h3333, 2'b10);
        push_prdy();
        prog_pulse(23'h000010, 8'h33);
        prog_pulse(23'h000021, 8'h77);
        wait_prdy("prog_b2b_rdy");
        repeat (20) @(negedge clk);
        slot_req = '0;
        @(negedge clk);
        downloading = 1'b0;
        repeat (3) @(negedge clk);

        // Refresh window opens together with a slot 1 request
        push_cmd(1'b0, 1'b1, 22'h000000, 16'h0000, 2'b00);
        push_cmd(1'b0, 1'b0, 22'h03C0D, 16'h0000, 2'b00);
        push_ok(4'b0010, rd_data(22'h03C0D));
        @(negedge clk);
        slot_addr[1*AW +: AW] = 22'h03C0D;
        slot_req[1] = 1'b1;
        rfsh_win = 1'b1;
        wait_ok(1, "rfsh_then_slot_ok");
        slot_req = '0;
        repeat (85) @(negedge clk);
        rfsh_win = 1'b0;
        repeat (5) @(negedge clk);

        // Reset while waiting for a slow controller
        ctl_lat = 12;
        push_cmd(1'b0, 1'b0, 22'h2AAAA, 16'h0000, 2'b00);
        @(negedge clk);
        slot_addr[0 +: AW] = 22'h2AAAA;
        slot_req[0] = 1'b1;
        begin
            bit acked = 1'b0;
            for (int i = 0; i < 50 && !acked; i++) begin
                @(negedge clk);
                if (sdram_ack) acked = 1'b1;
            end
            check("reset_test_ack", 96'(acked), 96'(1));
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        slot_req = '0;
        @(negedge clk);
        check("mid_wait_reset_outputs", all_outs(), 96'(0));
        rst = 1'b0;
        repeat (25) @(negedge clk);

        check("scoreboard_drained", 96'(sb.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
